// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial feeder for the sequence-detector FSM: one word in over valid/ready, one bit per clock out on x.
// Define FSM_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module fsm_bit_serializer #(
  parameter int WIDTH     = 10,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_MAX = (WIDTH > GAP + 1) ? WIDTH : GAP + 1;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int SW      = WIDTH - 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    GAP_ST = 2'd2
`ifdef FSM_SERIALIZER_PARITY_EN
    , PAR  = 2'd3
`endif
  } state_t;

  state_t          state_reg, state_next;
  // Holds only the bits not yet on x; the bit currently on x lives in x_reg.
  logic [SW-1:0]   sh_reg, sh_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            x_reg, x_next;
  logic            xv_reg, xv_next;
  logic            done_reg, done_next;
`ifdef FSM_SERIALIZER_PARITY_EN
  logic            par_reg, par_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sh_reg    <= '0;
      cnt_reg   <= '0;
      x_reg     <= 1'b0;
      xv_reg    <= 1'b0;
      done_reg  <= 1'b0;
`ifdef FSM_SERIALIZER_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      sh_reg    <= sh_next;
      cnt_reg   <= cnt_next;
      x_reg     <= x_next;
      xv_reg    <= xv_next;
      done_reg  <= done_next;
`ifdef FSM_SERIALIZER_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    sh_next    = sh_reg;
    cnt_next   = cnt_reg;
    x_next     = 1'b0;
    xv_next    = 1'b0;
    done_next  = 1'b0;
`ifdef FSM_SERIALIZER_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (din_valid) begin
          sh_next    = (MSB_FIRST != 0) ? din[WIDTH-2:0] : din[WIDTH-1:1];
          x_next     = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
          xv_next    = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = SHIFT;
`ifdef FSM_SERIALIZER_PARITY_EN
          par_next   = ^din;
`endif
        end
      end
      SHIFT: begin
        if (cnt_reg != '0) begin
          x_next   = (MSB_FIRST != 0) ? sh_reg[SW-1] : sh_reg[0];
          sh_next  = (MSB_FIRST != 0) ? (sh_reg << 1) : (sh_reg >> 1);
          xv_next  = 1'b1;
          cnt_next = cnt_reg - CW'(1);
`ifndef FSM_SERIALIZER_PARITY_EN
          done_next = (cnt_reg == CW'(1));
`endif
        end else begin
`ifdef FSM_SERIALIZER_PARITY_EN
          state_next = PAR;
          x_next     = par_reg;
          xv_next    = 1'b1;
          done_next  = 1'b1;
`else
          if (GAP > 0) begin
            state_next = GAP_ST;
            cnt_next   = GAP_LOAD;
          end else begin
            state_next = IDLE;
          end
`endif
        end
      end
`ifdef FSM_SERIALIZER_PARITY_EN
      PAR: begin
        if (GAP > 0) begin
          state_next = GAP_ST;
          cnt_next   = GAP_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
`endif
      GAP_ST: begin
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  assign din_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign x         = x_reg;
  assign x_valid   = xv_reg;
  assign done      = done_reg;

endmodule
